// File: rtl/rv_irq_ctrl.sv
// Machine-level interrupt controller: synchronises and latches IRQ sources, reports mip,
// arbitrates enabled pending sources and holds a trap request with a stable mcause until ack.
module rv_irq_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  LIRQ_EDGE   = 7'h7F
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mie,
    input  logic [18:0] ir_in,
    output logic [18:0] ir_out,
    output logic        interrupt_exec_o,
    input  logic        interrupt_ack_i,
    output logic [4:0]  mcause_o,
    input  logic        ext_irq_in,
    input  logic [6:0]  l_irq_in,
    input  logic        timer_irq_in,
    input  logic        software_irq_in
);

    localparam logic [4:0] CauseMsi   = 5'd3;
    localparam logic [4:0] CauseMti   = 5'd7;
    localparam logic [4:0] CauseMei   = 5'd11;
    localparam logic [4:0] CauseLirq0 = 5'd16;

    typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

    state_e                          state_q, state_d;
    logic   [4:0]                    mcause_q, mcause_d;
    logic   [SYNC_STAGES-1:0]        ext_sync_q;
    logic   [SYNC_STAGES-1:0][6:0]   lirq_sync_q;
    logic   [6:0]                    lirq_prev_q;
    logic   [6:0]                    sticky_q, sticky_d;
    logic   [18:0]                   ir_q, ir_d;

    logic        ext_s;
    logic [6:0]  lirq_s;
    logic [6:0]  lirq_rise;
    logic [6:0]  lirq_clr;
    logic [6:0]  lirq_pend;
    logic [9:0]  pend_en;
    logic [9:0]  cause_sel;
    logic [4:0]  win_cause;
    logic        latched_live;
    logic        unused_ir_in;

    assign unused_ir_in = ^ir_in[18:10];

    assign ext_s  = ext_sync_q[SYNC_STAGES-1];
    assign lirq_s = lirq_sync_q[SYNC_STAGES-1];

    // Pending view seen by the arbiter is the registered mip image.
    assign pend_en = ir_q[9:0] & ir_in[9:0];

    always_comb begin
        win_cause = '0;
        // Later assignments override earlier ones, so the highest priority is written last.
        for (int i = 6; i >= 0; i--) begin
            if (pend_en[3+i]) win_cause = CauseLirq0 + 5'(i);
        end
        if (pend_en[1]) win_cause = CauseMti;
        if (pend_en[0]) win_cause = CauseMsi;
        if (pend_en[2]) win_cause = CauseMei;
    end

    always_comb begin
        cause_sel = '0;
        if (mcause_q == CauseMsi) cause_sel[0] = 1'b1;
        if (mcause_q == CauseMti) cause_sel[1] = 1'b1;
        if (mcause_q == CauseMei) cause_sel[2] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (mcause_q == CauseLirq0 + 5'(i)) cause_sel[3+i] = 1'b1;
        end
    end

    assign latched_live = mie & |(cause_sel & pend_en);

    always_comb begin
        lirq_rise = lirq_s & ~lirq_prev_q & LIRQ_EDGE;
        lirq_clr  = '0;
        if (state_q == StReq && interrupt_ack_i) lirq_clr = cause_sel[9:3] & LIRQ_EDGE;
        // A fresh edge in the ack cycle must not be lost, so set dominates clear.
        sticky_d  = (sticky_q & ~lirq_clr) | lirq_rise;
        lirq_pend = (sticky_d & LIRQ_EDGE) | (lirq_s & ~LIRQ_EDGE);
        ir_d      = {9'b0, lirq_pend, ext_s, timer_irq_in, software_irq_in};
    end

    always_comb begin
        state_d  = state_q;
        mcause_d = mcause_q;
        unique case (state_q)
            StIdle: begin
                if (mie && |pend_en) begin
                    mcause_d = win_cause;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (interrupt_ack_i) begin
                    state_d = StHold;
                end else if (!latched_live) begin
                    state_d = StIdle;
                end
            end
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            mcause_q    <= '0;
            ext_sync_q  <= '0;
            lirq_sync_q <= '0;
            lirq_prev_q <= '0;
            sticky_q    <= '0;
            ir_q        <= '0;
        end else begin
            state_q     <= state_d;
            mcause_q    <= mcause_d;
            ext_sync_q  <= {ext_sync_q[SYNC_STAGES-2:0], ext_irq_in};
            lirq_sync_q <= {lirq_sync_q[SYNC_STAGES-2:0], l_irq_in};
            lirq_prev_q <= lirq_s;
            sticky_q    <= sticky_d;
            ir_q        <= ir_d;
        end
    end

    assign ir_out           = ir_q;
    assign mcause_o         = mcause_q;
    assign interrupt_exec_o = (state_q == StReq);

endmodule

// File: tb/tb_rv_irq_ctrl.sv
// Scoreboard bench for rv_irq_ctrl: expected causes are queued by the stimulus and checked
// by a monitor whenever a trap request is presented.
module tb_rv_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mie;
    logic [18:0] ir_in;
    logic [18:0] ir_out;
    logic        interrupt_exec_o;
    logic        interrupt_ack_i;
    logic [4:0]  mcause_o;
    logic        ext_irq_in;
    logic [6:0]  l_irq_in;
    logic        timer_irq_in;
    logic        software_irq_in;

    int          checks = 0;
    int          errors = 0;
    logic [4:0]  exp_q[$];
    logic [4:0]  cur_exp = '0;
    logic        exec_seen = 1'b0;

    always #5 clk_i = ~clk_i;

    rv_irq_ctrl #(
        .SYNC_STAGES(2),
        .LIRQ_EDGE  (7'h7F)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .mie             (mie),
        .ir_in           (ir_in),
        .ir_out          (ir_out),
        .interrupt_exec_o(interrupt_exec_o),
        .interrupt_ack_i (interrupt_ack_i),
        .mcause_o        (mcause_o),
        .ext_irq_in      (ext_irq_in),
        .l_irq_in        (l_irq_in),
        .timer_irq_in    (timer_irq_in),
        .software_irq_in (software_irq_in)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic ack_pulse();
        interrupt_ack_i = 1'b1;
        step(1);
        interrupt_ack_i = 1'b0;
    endtask

    initial begin
        rst_ni          = 1'b0;
        mie             = 1'b0;
        ir_in           = '0;
        interrupt_ack_i = 1'b0;
        ext_irq_in      = 1'b0;
        l_irq_in        = '0;
        timer_irq_in    = 1'b0;
        software_irq_in = 1'b0;

        fork
            forever begin
                @(negedge clk_i);
                if (interrupt_exec_o && !exec_seen) begin
                    chk("req_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
                end
                if (interrupt_exec_o) chk("mcause_in_req", 32'(mcause_o), 32'(cur_exp));
                exec_seen = interrupt_exec_o;
            end
        join_none

        step(2);
        chk("rst_exec", 32'(interrupt_exec_o), 0);
        chk("rst_mcause", 32'(mcause_o), 0);
        chk("rst_ir_out", 32'(ir_out), 0);
        rst_ni = 1'b1;
        step(2);

        // External IRQ latency and ack; ack coincides with loss of enable.
        exp_q.push_back(5'd11);
        mie = 1'b1; ir_in = 19'h4; ext_irq_in = 1'b1;
        step(3);
        chk("ext_lat_early", 32'(interrupt_exec_o), 0);
        step(1);
        chk("ext_lat_exec", 32'(interrupt_exec_o), 1);
        chk("ext_cause", 32'(mcause_o), 11);
        chk("ext_ir_out", 32'(ir_out), 32'h4);
        interrupt_ack_i = 1'b1; ext_irq_in = 1'b0; ir_in = '0;
        step(1);
        interrupt_ack_i = 1'b0;
        chk("ext_ack_drop", 32'(interrupt_exec_o), 0);
        step(5);
        chk("ext_idle", 32'(interrupt_exec_o), 0);
        chk("ext_ir_clear", 32'(ir_out), 0);

        // Three level sources: MEI wins, withdraws when ext drops, MSI follows.
        exp_q.push_back(5'd11);
        exp_q.push_back(5'd3);
        ir_in = 19'h7; ext_irq_in = 1'b1;
        step(2);
        software_irq_in = 1'b1; timer_irq_in = 1'b1;
        step(2);
        chk("prio_exec", 32'(interrupt_exec_o), 1);
        chk("prio_cause", 32'(mcause_o), 11);
        ext_irq_in = 1'b0;
        step(3);
        chk("prio_still_req", 32'(interrupt_exec_o), 1);
        step(1);
        chk("prio_withdraw", 32'(interrupt_exec_o), 0);
        step(1);
        chk("prio_rereq", 32'(interrupt_exec_o), 1);
        chk("prio_cause_msi", 32'(mcause_o), 3);
        interrupt_ack_i = 1'b1; software_irq_in = 1'b0; timer_irq_in = 1'b0; ir_in = '0;
        step(1);
        interrupt_ack_i = 1'b0;
        step(4);

        // Sticky local IRQ held while mie=0, cleared by ack.
        mie = 1'b0; ir_in = 19'h20;
        l_irq_in[2] = 1'b1;
        step(1);
        l_irq_in[2] = 1'b0;
        step(5);
        chk("lirq2_sticky", 32'(ir_out[5]), 1);
        chk("lirq2_masked", 32'(interrupt_exec_o), 0);
        exp_q.push_back(5'd18);
        mie = 1'b1;
        step(1);
        chk("lirq2_exec", 32'(interrupt_exec_o), 1);
        chk("lirq2_cause", 32'(mcause_o), 18);
        ack_pulse();
        chk("lirq2_cleared", 32'(ir_out), 0);
        chk("lirq2_ack_drop", 32'(interrupt_exec_o), 0);
        step(3);
        chk("lirq2_idle", 32'(interrupt_exec_o), 0);

        // New lirq0 edge landing exactly in the ack cycle keeps the bit pending.
        exp_q.push_back(5'd16);
        exp_q.push_back(5'd16);
        ir_in = 19'h8;
        l_irq_in[0] = 1'b1;
        step(1);
        l_irq_in[0] = 1'b0;
        step(3);
        chk("lirq0_exec", 32'(interrupt_exec_o), 1);
        l_irq_in[0] = 1'b1;
        step(2);
        ack_pulse();
        l_irq_in[0] = 1'b0;
        chk("lirq0_set_wins", 32'(ir_out[3]), 1);
        chk("lirq0_hold", 32'(interrupt_exec_o), 0);
        step(1);
        chk("lirq0_idle_gap", 32'(interrupt_exec_o), 0);
        step(1);
        chk("lirq0_rereq", 32'(interrupt_exec_o), 1);
        chk("lirq0_rereq_cause", 32'(mcause_o), 16);
        ack_pulse();
        chk("lirq0_cleared", 32'(ir_out[3]), 0);
        step(3);

        // mcause frozen while a higher-priority local source arrives.
        exp_q.push_back(5'd17);
        exp_q.push_back(5'd16);
        ir_in = 19'h18;
        l_irq_in[1] = 1'b1;
        step(1);
        l_irq_in[1] = 1'b0;
        step(3);
        l_irq_in[0] = 1'b1;
        step(1);
        l_irq_in[0] = 1'b0;
        step(3);
        chk("freeze_exec", 32'(interrupt_exec_o), 1);
        chk("freeze_cause", 32'(mcause_o), 17);
        chk("freeze_lirq0_pend", 32'(ir_out[3]), 1);
        ack_pulse();
        step(2);
        chk("freeze_next_exec", 32'(interrupt_exec_o), 1);
        chk("freeze_next_cause", 32'(mcause_o), 16);
        ack_pulse();
        ir_in = '0;
        step(3);

        // Asynchronous reset while a request is active.
        exp_q.push_back(5'd11);
        ir_in = 19'h4; ext_irq_in = 1'b1;
        step(4);
        chk("rreq_exec", 32'(interrupt_exec_o), 1);
        chk("rreq_cause", 32'(mcause_o), 11);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_exec", 32'(interrupt_exec_o), 0);
        chk("arst_mcause", 32'(mcause_o), 0);
        chk("arst_ir_out", 32'(ir_out), 0);
        ext_irq_in = 1'b0;
        step(1);
        rst_ni = 1'b1;
        step(4);
        chk("post_rst_idle", 32'(interrupt_exec_o), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
